skolem_sweep_checker: RTL

- Sequential harness that sits directly upstream and downstream of a combinational Skolem-function netlist for the bvand equation x & s = t.
- Exhaustively drives every (s, t) pair into the netlist and reads back the candidate x.
- Checks x against the invertibility condition IC = ((t & ~s) == 0) and reports counts plus the first failing vector.
- Used to sign off ABC-generated Skolem netlists in hardware or simulation without a separate testbench model.

---
 rtl/skolem_sweep_checker_if.sv | 31 +++
 rtl/skolem_sweep_checker.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/skolem_sweep_checker_if.sv
// Bundles the sweep control/status signals and the netlist-facing operand bus.
// master: the checker itself; slave: whoever drives start/abort and returns x_in.
interface skolem_sweep_checker_if #(
    parameter int unsigned W = 4
);
    logic           start;
    logic           abort;
    logic [W-1:0]   s_out;
    logic [W-1:0]   t_out;
    logic [W-1:0]   x_in;
    logic           busy;
    logic           done;
    logic           pass;
    logic [2*W:0]   ic_count;
    logic [2*W:0]   fail_count;
    logic           first_fail_valid;
    logic [W-1:0]   first_fail_s;
    logic [W-1:0]   first_fail_t;

    modport master (
        input  start, abort, x_in,
        output s_out, t_out, busy, done, pass, ic_count, fail_count,
               first_fail_valid, first_fail_s, first_fail_t
    );

    modport slave (
        output start, abort, x_in,
        input  s_out, t_out, busy, done, pass, ic_count, fail_count,
               first_fail_valid, first_fail_s, first_fail_t
    );
endinterface

// File: rtl/skolem_sweep_checker.sv
// Exhaustive sweep harness for a combinational Skolem netlist solving x & s = t.
// Every (s, t) pair is presented for LAT settle cycles, then x_in is checked in a
// single CHECK cycle whenever the invertibility condition (t & ~s) == 0 holds.
// LAT must be at least 1.
module skolem_sweep_checker #(
    parameter int unsigned W   = 4,
    parameter int unsigned LAT = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    skolem_sweep_checker_if.master bus
);

    localparam int unsigned IdxW = 2 * W;
    localparam int unsigned CntW = 2 * W + 1;
    localparam int unsigned LatW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [LatW-1:0] LatLast = LatW'(LAT - 1);
    localparam logic [IdxW-1:0] IdxLast = '1;

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [LatW-1:0] lat_q, lat_d;
    logic [W-1:0]    s_q, s_d;
    logic [W-1:0]    t_q, t_d;
    logic [CntW-1:0] ic_q, ic_d;
    logic [CntW-1:0] fail_q, fail_d;
    logic            ffv_q, ffv_d;
    logic [W-1:0]    ffs_q, ffs_d;
    logic [W-1:0]    fft_q, fft_d;

    logic            start_ok;
    logic            ic_hold;
    logic            x_bad;
    logic [IdxW-1:0] idx_inc;

    // Start is honoured only when no sweep is running; abort only while busy.
    assign start_ok = bus.start && (state_q == StIdle || state_q == StDone);
    assign ic_hold  = ((t_q & ~s_q) == '0);
    assign x_bad    = ((bus.x_in & s_q) != t_q);
    assign idx_inc  = idx_q + IdxW'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides both the SETTLE and CHECK transitions.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.start) state_d = StSettle;
            StSettle: begin
                if (bus.abort)             state_d = StIdle;
                else if (lat_q == LatLast) state_d = StCheck;
            end
            StCheck: begin
                if (bus.abort)             state_d = StIdle;
                else if (idx_q == IdxLast) state_d = StDone;
                else                       state_d = StSettle;
            end
            StDone:   if (bus.start) state_d = StSettle;
            default:  state_d = StIdle;
        endcase
    end

    // Status outputs decode straight from the registered state and results.
    always_comb begin
        bus.busy             = (state_q == StSettle) || (state_q == StCheck);
        bus.done             = (state_q == StDone);
        bus.pass             = (state_q == StDone) && (fail_q == '0);
        bus.s_out            = s_q;
        bus.t_out            = t_q;
        bus.ic_count         = ic_q;
        bus.fail_count       = fail_q;
        bus.first_fail_valid = ffv_q;
        bus.first_fail_s     = ffs_q;
        bus.first_fail_t     = fft_q;
    end

    // Datapath next-state: vector index, settle timer, operands and result counters.
    always_comb begin
        idx_d  = idx_q;
        lat_d  = lat_q;
        s_d    = s_q;
        t_d    = t_q;
        ic_d   = ic_q;
        fail_d = fail_q;
        ffv_d  = ffv_q;
        ffs_d  = ffs_q;
        fft_d  = fft_q;
        if (start_ok) begin
            idx_d  = '0;
            lat_d  = '0;
            s_d    = '0;
            t_d    = '0;
            ic_d   = '0;
            fail_d = '0;
            ffv_d  = 1'b0;
            ffs_d  = '0;
            fft_d  = '0;
        end else if (state_q == StSettle && !bus.abort) begin
            lat_d = lat_q + LatW'(1);
        end else if (state_q == StCheck && !bus.abort) begin
            // Vectors violating IC are skipped: any x is acceptable there.
            if (ic_hold) begin
                ic_d = ic_q + CntW'(1);
                if (x_bad) begin
                    fail_d = fail_q + CntW'(1);
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffs_d = s_q;
                        fft_d = t_q;
                    end
                end
            end
            // Operands only move when entering the next SETTLE window.
            if (idx_q != IdxLast) begin
                idx_d = idx_inc;
                lat_d = '0;
                s_d   = idx_inc[IdxW-1:W];
                t_d   = idx_inc[W-1:0];
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            lat_q  <= '0;
            s_q    <= '0;
            t_q    <= '0;
            ic_q   <= '0;
            fail_q <= '0;
            ffv_q  <= 1'b0;
            ffs_q  <= '0;
            fft_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            lat_q  <= lat_d;
            s_q    <= s_d;
            t_q    <= t_d;
            ic_q   <= ic_d;
            fail_q <= fail_d;
            ffv_q  <= ffv_d;
            ffs_q  <= ffs_d;
            fft_q  <= fft_d;
        end
    end

endmodule
